// File: rtl/bus_ctrl.sv
// Peripheral bus sequencer: latches one MEM-stage bus access, runs a req/ack handshake with timeout, stalls the pipe meanwhile.
// Latency: stall from the access cycle until ack (min 2 cycles) or TIMEOUT+1 cycles on timeout; result registered.
// Backpressure: single outstanding transaction; stall_bus holds the pipeline, request inputs ignored outside IDLE.
module bus_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_sel,
    input  logic              mem_we_M,
    input  logic              mem_re_M,
    input  logic [DATA_W-1:0] addr_bus,
    input  logic [DATA_W-1:0] wdata_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stall_bus,
    output logic [DATA_W-1:0] rdata_bus,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                access;

    assign access = m_sel & (mem_we_M | mem_re_M);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = addr_bus;
                    wdata_d = wdata_M;
                    we_d    = mem_we_M;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Ack takes priority, even on the final timeout cycle.
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall covers the access cycle itself so the MEM stage freezes before REQ starts.
    assign stall_bus = rst_n & ((state_q == REQ) | ((state_q == IDLE) & access));
    assign bus_req   = (state_q == REQ);
    assign bus_we    = (state_q == REQ) & we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata_bus = rdata_q;
    assign bus_err   = (state_q == ERR);

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Sequences MEM-stage accesses that the address decoder routes to the peripheral bus (`m_sel`=1, address ≥ 0x4FF). It latches the access and drives a single-outstanding req/ack bus transaction. It stalls the pipeline until the peripheral acknowledges or a timeout expires, then returns registered read data and an error flag to the MEM/WB path. Accesses with `m_sel`=0 (data memory) pass by untouched: no stall, no bus activity.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles spent in REQ waiting for `bus_ack` (≥2).
- `DATA_W`, 32: address/data width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `m_sel` in 1: decoder select, 1 = bus region.
- `mem_we_M` in 1: MEM-stage store.
- `mem_re_M` in 1: MEM-stage load.
- `addr_bus` in DATA_W: bus-region address from the decoder.
- `wdata_M` in DATA_W: store data.
- `bus_req` out 1: transaction request, held until ack or timeout.
- `bus_we` out 1: 1 = write.
- `bus_addr` out DATA_W: latched address.
- `bus_wdata` out DATA_W: latched write data.
- `bus_rdata` in DATA_W: peripheral read data, valid with `bus_ack`.
- `bus_ack` in 1: one-cycle completion strobe from the peripheral.
- `stall_bus` out 1: freeze PC/IF/ID/EX/MEM registers.
- `rdata_bus` out DATA_W: registered load result for WB.
- `bus_err` out 1: one-cycle pulse, transaction timed out.

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - Access = `m_sel & (mem_we_M | mem_re_M)`.
  - On an access: latch `addr_bus`, `wdata_M` and `we = mem_we_M` (we and re both high means write), clear the counter, go to REQ.
  - `stall_bus` is asserted combinationally in the same cycle the access is seen.
- REQ:
  - `bus_req`=1 and `stall_bus`=1.
  - `bus_addr`, `bus_we` and `bus_wdata` are stable, driven from the latches.
  - Counter increments each cycle.
  - If `bus_ack`: capture `bus_rdata` into `rdata_bus` (writes capture it too; the value is don't-care), go to DONE.
  - Else if counter == TIMEOUT-1: go to ERR.
  - Ack on the timeout cycle wins and goes to DONE.
- DONE: `stall_bus`=0 for exactly one cycle so MEM advances; request inputs ignored; go to IDLE.
- ERR: `stall_bus`=0, `bus_err`=1, `rdata_bus` forced to 0; go to IDLE.
- `bus_ack` outside REQ is ignored.
- `rdata_bus` holds its value until the next capture or error.
- Counter width: clog2(TIMEOUT); it never wraps in REQ.
- Outside REQ: `bus_req`=0 and `bus_we`=0; `bus_addr`/`bus_wdata` hold the last latched values.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - state IDLE, counter 0.
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `rdata_bus`=0, `bus_err`=0.
  - `stall_bus`=0 while `rst_n`=0.
- Reset mid-REQ: `bus_req` drops at that edge; the transaction is abandoned with no error pulse.
- Cycle numbering: access seen in cycle 0 (IDLE, stall=1); REQ starts in cycle 1.
- Ack in cycle k (k ≥ 1) gives DONE in cycle k+1:
  - stall high in cycles 0..k.
  - `rdata_bus` valid from cycle k+1.
  - Minimum latency is 2 stall cycles.
- No ack: REQ runs cycles 1..TIMEOUT, ERR is in cycle TIMEOUT+1, total stall is TIMEOUT+1 cycles.
- Back-to-back bus accesses: the second access is seen in IDLE the cycle after DONE/ERR; there is no dead cycle beyond DONE.
- A data-memory access (`m_sel`=0) in IDLE: stall stays 0 and state stays IDLE.

## Test plan
- Load at 0x0000_0500, ack asserted in cycle 3 with `bus_rdata`=0x1234_5678 → `stall_bus` high cycles 0–3; `bus_req` high cycles 1–3 with `bus_we`=0 and `bus_addr`=0x500; `rdata_bus`=0x1234_5678 from cycle 4; `bus_err`=0.
- Store 0xCAFE_0001 to 0x600, ack in cycle 1 → `bus_we`=1 and `bus_wdata`=0xCAFE_0001 in cycle 1; stall released in cycle 2 (2 stall cycles).
- TIMEOUT=16, load with no ack → `bus_req` high cycles 1–16; `bus_err` pulse in cycle 17; `rdata_bus`=0; stall low in cycle 17; IDLE in cycle 18.
- Ack exactly in cycle 16 (the timeout cycle) → DONE, data captured, no `bus_err`.
- `rst_n`=0 in cycle 3 of an unacked REQ → `bus_req`=0 and all outputs at reset values from the next edge; a late ack in cycle 5 is ignored.
- `m_sel`=0 with `mem_re_M`=1 → no `bus_req`, `stall_bus`=0 throughout. Two consecutive bus loads, each acked after 1 cycle → second `bus_req` rises two cycles after the first DONE.
